arcade_key_mapper: RTL
======================

Name: arcade_key_mapper

Overview:
- Parametrised replacement for the hard-coded PS/2 case-decode and button-OR logic in arcade top levels.
- Holds a runtime-loadable keymap of NUM_BTN entries and tracks key make/break events from the hps_io ps2_key bus.
- Merges key state with joystick bits, then applies per-button autofire and per-button pulse stretching (coin).
- Sits between hps_io and the game core; outputs are registered button levels in the clk_sys domain.

Parameters:
- NUM_BTN, 16, number of mapped buttons (legal range 2..32).
- AF_DIV, 550000, clk_sys cycles per autofire half-period (≈10 Hz at 11 MHz).
- PULSE_LEN, 1100000, minimum output high time in cycles for pulse-enabled buttons (≈100 ms). Must be ≥2.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- map_wr  in  1  keymap write strobe.
- map_idx  in  $clog2(NUM_BTN)  keymap entry to write.
- map_data  in  11  [10] valid, [9] ignore-extended, [8:0] {ext, scancode}.
- joy_in  in  NUM_BTN  joystick bits, active high, ORed per button.
- af_en  in  NUM_BTN  per-button autofire enable.
- pulse_en  in  NUM_BTN  per-button pulse-stretch enable.
- btn_out  out  NUM_BTN  final button levels, active high.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge) clears the following. Normal operation resumes on the first edge with reset_n=1.
  - All keymap valid bits, key_state, and pulse counters go to 0.
  - btn_out goes to 0.
  - old_toggle is loaded from ps2_key[10], so no spurious event is taken after reset.
  - af_cnt goes to 0 and af_phase goes to 1.
- Event detect:
  - An event occurs in a cycle when ps2_key[10] != old_toggle; old_toggle <= ps2_key[10] every cycle.
  - Entry i matches when valid=1 and scancode equals ps2_key[7:0], and either ignore-extended=1 or ext equals ps2_key[8].
  - On an event, every matching entry sets key_state[i] <= ps2_key[9]. Multiple matches are allowed; non-matching entries are unchanged.
- Keymap write:
  - map_wr=1 updates entry map_idx at that edge.
  - If an event occurs in the same cycle, the event uses the pre-write table.
  - Writing an entry does not change its key_state.
  - map_idx ≥ NUM_BTN is ignored.
- held[i] = key_state[i] | joy_in[i] (combinational).
- Autofire:
  - af_cnt counts 0..AF_DIV-1 and wraps; af_phase toggles on each wrap.
  - af_cnt is held at 0 with af_phase forced to 1 while no af_en button is held, so a first press fires immediately.
  - af_out[i] = held[i] & (af_en[i] ? af_phase : 1).
- Pulse stretch, for pulse_en[i]=1:
  - A rising edge of af_out[i] while cnt[i]==0 loads cnt[i]=PULSE_LEN-1.
  - While cnt[i]≠0, cnt[i] decrements each cycle.
  - Stage output = (cnt[i]≠0) | rising-edge cycle. The output is high for exactly PULSE_LEN cycles regardless of release.
  - Re-presses during an active pulse are ignored; a press still held after expiry does not retrigger.
- For pulse_en[i]=0 the stage output is af_out[i].
- btn_out is the registered stage output.
- Latency:
  - ps2_key toggle change at edge N → key_state updates at N+1 → btn_out at N+2.
  - joy_in change → btn_out 1 cycle later.
- Changing af_en or pulse_en mid-operation takes effect the next cycle. Clearing pulse_en mid-pulse zeroes cnt[i].

Test Plan:
- Map entry 0 = {valid, ign-ext, 0x075}; drive ps2_key {toggle flip, pressed=1, ext=1, 0x75} → btn_out[0]=1 two cycles later. Break event (pressed=0) → btn_out[0]=0 two cycles later.
- Map entries 2 and 5 both to 0x029; one make event → btn_out[2] and btn_out[5] both 1. Code 0x14 with ext=1 against entry ext=0, ign-ext=0 → no change.
- Keep ps2_key[10] static with pressed=1 for 100 cycles → no output change. Assert reset_n=0 while btn_out[0]=1 → all outputs 0 next edge, keymap invalid, and a subsequent event matches nothing.
- AF_DIV=4, af_en[4]=1, hold joy_in[4] → btn_out[4] pattern 1111 0000 1111 0000 starting one cycle after press. Release and re-press → starts high again.
- PULSE_LEN=8, pulse_en[7]=1, joy_in[7] high for 2 cycles → btn_out[7] high exactly 8 cycles. Re-press at cycle 4 → no extension. Hold 20 cycles → single 8-cycle pulse.
- Same-cycle map_wr of entry 1 to 0x016 with a 0x016 make event → btn_out[1] stays 0. Next make event → btn_out[1]=1.

Source files
------------

// File: rtl/arcade_key_mapper_if.sv
// Host-side bus from hps_io into the key mapper: PS/2 key events plus the keymap write port.
interface arcade_key_mapper_if #(
    parameter int unsigned NUM_BTN = 16
);
    localparam int unsigned IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    logic [10:0]   ps2_key;
    logic          map_wr;
    logic [IW-1:0] map_idx;
    logic [10:0]   map_data;

    modport master (output ps2_key, map_wr, map_idx, map_data);
    modport slave  (input  ps2_key, map_wr, map_idx, map_data);
endinterface

// File: rtl/arcade_key_mapper.sv
// Runtime-loadable PS/2 keymap merged with joystick bits, followed by per-button
// autofire and pulse stretching; all button levels registered in clk_sys.
module arcade_key_mapper #(
    parameter int unsigned NUM_BTN   = 16,
    parameter int unsigned AF_DIV    = 550000,
    parameter int unsigned PULSE_LEN = 1100000
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    arcade_key_mapper_if.slave   keys,
    input  logic [NUM_BTN-1:0]   joy_in,
    input  logic [NUM_BTN-1:0]   af_en,
    input  logic [NUM_BTN-1:0]   pulse_en,
    output logic [NUM_BTN-1:0]   btn_out
);
    localparam int unsigned AW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    localparam int unsigned CW = $clog2(PULSE_LEN);
    localparam logic [AW-1:0] AF_LAST    = AW'(AF_DIV - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);

    logic               old_toggle;
    logic [NUM_BTN-1:0] map_valid;
    logic [NUM_BTN-1:0] map_ign;
    logic [8:0]         map_code [NUM_BTN];
    logic [NUM_BTN-1:0] key_state;
    logic [AW-1:0]      af_cnt;
    logic               af_phase;
    logic [NUM_BTN-1:0] af_prev;
    logic [CW-1:0]      pulse_cnt [NUM_BTN];

    logic               ps2_event;
    logic               af_active;
    logic [NUM_BTN-1:0] match;
    logic [NUM_BTN-1:0] held;
    logic [NUM_BTN-1:0] af_out;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] stage;

    // Keymap match, merge, autofire gating and pulse-stage output.
    always_comb begin
        ps2_event = keys.ps2_key[10] != old_toggle;
        held      = key_state | joy_in;
        af_active = |(held & af_en);
        match     = '0;
        af_out    = '0;
        rise      = '0;
        stage     = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            match[i]  = map_valid[i]
                        && (map_code[i][7:0] == keys.ps2_key[7:0])
                        && (map_ign[i] || (map_code[i][8] == keys.ps2_key[8]));
            af_out[i] = held[i] & (af_en[i] ? af_phase : 1'b1);
            rise[i]   = af_out[i] & ~af_prev[i];
            stage[i]  = pulse_en[i] ? ((pulse_cnt[i] != '0) | rise[i]) : af_out[i];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            old_toggle <= keys.ps2_key[10];
            map_valid  <= '0;
            map_ign    <= '0;
            key_state  <= '0;
            af_cnt     <= '0;
            af_phase   <= 1'b1;
            af_prev    <= '0;
            btn_out    <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                map_code[i]  <= '0;
                pulse_cnt[i] <= '0;
            end
        end else begin
            old_toggle <= keys.ps2_key[10];

            // Matching uses the table as it stood before any same-cycle write.
            if (ps2_event) begin
                for (int i = 0; i < int'(NUM_BTN); i++) begin
                    if (match[i]) key_state[i] <= keys.ps2_key[9];
                end
            end

            if (keys.map_wr && (32'(keys.map_idx) < NUM_BTN)) begin
                map_valid[keys.map_idx] <= keys.map_data[10];
                map_ign[keys.map_idx]   <= keys.map_data[9];
                map_code[keys.map_idx]  <= keys.map_data[8:0];
            end

            // Parked at phase 1 while idle so the first autofire press fires at once.
            if (!af_active) begin
                af_cnt   <= '0;
                af_phase <= 1'b1;
            end else if (af_cnt == AF_LAST) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + AW'(1);
            end

            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (!pulse_en[i])
                    pulse_cnt[i] <= '0;
                else if (pulse_cnt[i] != '0)
                    pulse_cnt[i] <= pulse_cnt[i] - CW'(1);
                else if (rise[i])
                    pulse_cnt[i] <= PULSE_LOAD;
            end

            af_prev <= af_out;
            btn_out <= stage;
        end
    end
endmodule
